nibble_serial_sub16: RTL and testbench

//  - Multi-cycle 16-bit unsigned/two's-complement subtractor, diff = a - b.
//  - Complements the 4-bit structural adder datapath: one 4-bit borrow-ripple slice is reused once per cycle, LSB nibble first.
//  - Sits beside the 16-bit ripple adder as the subtract path; start/done handshake to the controlling logic.

---
 rtl/sub16_pkg.sv | 21 ++
 rtl/sub4bit_slice.sv | 26 ++
 rtl/nibble_serial_sub16.sv | 115 +++++++++++
 tb/tb_nibble_serial_sub16.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sub16_pkg.sv
// Shared constants and types for the nibble-serial 16-bit subtractor.
package sub16_pkg;

   localparam int DEFAULT_WIDTH  = 16;
   localparam int DEFAULT_SLICE  = 4;
   localparam int DEFAULT_NSLICE = DEFAULT_WIDTH / DEFAULT_SLICE;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A one-slice configuration still needs a 1-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_NSLICE);

endpackage

// File: rtl/sub4bit_slice.sv
// Combinational borrow-ripple subtractor slice: d = x - y - bin, built from
// full-subtractor cells.
module sub4bit_slice
   import sub16_pkg::*;
#(
   parameter int SLICE_W = DEFAULT_SLICE
) (
   input  logic [SLICE_W-1:0] x,
   input  logic [SLICE_W-1:0] y,
   input  logic               bin,
   output logic [SLICE_W-1:0] d,
   output logic               bout
);

   logic [SLICE_W:0] chain;

   assign chain[0] = bin;

   for (genvar i = 0; i < SLICE_W; i++) begin : g_cell
      assign d[i]       = x[i] ^ y[i] ^ chain[i];
      assign chain[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & chain[i]);
   end

   assign bout = chain[SLICE_W];

endmodule

// File: rtl/nibble_serial_sub16.sv
// Multi-cycle subtractor: one SLICE-bit borrow-ripple slice reused per cycle,
// LSB slice first, with a start/done handshake.
module nibble_serial_sub16
   import sub16_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int SLICE = DEFAULT_SLICE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf,
   output logic             zero
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = cnt_width(NSLICE);
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);
   localparam int MSB    = WIDTH - 1;

   state_t state_q, state_d;

   logic [CW-1:0]    cnt_q;
   logic             bin_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] shadow_q, shadow_next;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q, ovf_q, zero_q;

   logic [SLICE-1:0] slice_d;
   logic             slice_bout;
   logic             accept, last_slice;

   assign accept     = start && (state_q != RUN);
   assign last_slice = (state_q == RUN) && (cnt_q == LAST);

   sub4bit_slice #(.SLICE_W(SLICE)) u_slice (
      .x    (a_q[cnt_q*SLICE +: SLICE]),
      .y    (b_q[cnt_q*SLICE +: SLICE]),
      .bin  (bin_q),
      .d    (slice_d),
      .bout (slice_bout)
   );

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      shadow_next = shadow_q;
      shadow_next[cnt_q*SLICE +: SLICE] = slice_d;
   end

   // NOTE: sequential state uses <= so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cnt_q == LAST) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q == RUN);
      done   = (state_q == DONE);
      diff   = diff_q;
      borrow = borrow_q;
      ovf    = ovf_q;
      zero   = zero_q;
   end

   // Visible flags load from shadow_next so the top slice lands in the same
   // edge that enters DONE; partial results never reach diff.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         bin_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         shadow_q <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         if (accept) begin
            a_q   <= a;
            b_q   <= b;
            cnt_q <= '0;
            bin_q <= 1'b0;
         end else if (state_q == RUN) begin
            shadow_q <= shadow_next;
            bin_q    <= slice_bout;
            cnt_q    <= cnt_q + CW'(1);
         end
         if (last_slice) begin
            diff_q   <= shadow_next;
            borrow_q <= slice_bout;
            ovf_q    <= (a_q[MSB] != b_q[MSB]) && (shadow_next[MSB] != a_q[MSB]);
            zero_q   <= (shadow_next == '0);
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_sub16.sv
// Directed self-checking bench for nibble_serial_sub16.
module tb_nibble_serial_sub16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] a, b;
   logic        busy, done;
   logic [15:0] diff;
   logic        borrow, ovf, zero;

   int total = 0;
   int bad   = 0;

   logic [15:0] ra, rb, rd;
   int          ndone;

   nibble_serial_sub16 dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .ovf    (ovf),
      .zero   (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_busy"},   busy,   0);
      check({tag, "_done"},   done,   0);
      check({tag, "_diff"},   diff,   0);
      check({tag, "_borrow"}, borrow, 0);
      check({tag, "_ovf"},    ovf,    0);
      check({tag, "_zero"},   zero,   0);
   endtask

   // One operation from an idle start: latency, busy length, results, single-cycle done.
   task automatic run_vec(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] ed, input logic eb, input logic eo, input logic ez);
      int lat, busy_cnt;
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(posedge clk);
      lat = 0; busy_cnt = 0;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 20; n++) begin
         lat++;
         if (busy) busy_cnt++;
         if (done) break;
         @(negedge clk);
      end
      check({tag, "_latency"},  lat,      5);
      check({tag, "_busy_len"}, busy_cnt, 4);
      check({tag, "_busy_at_done"}, busy, 0);
      check({tag, "_diff"},   diff,   ed);
      check({tag, "_borrow"}, borrow, eb);
      check({tag, "_ovf"},    ovf,    eo);
      check({tag, "_zero"},   zero,   ez);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_diff_hold"},  diff, ed);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b1; a = 16'hDEAD; b = 16'hBEEF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_cleared("reset");
      rst_n = 1'b1; start = 1'b0;
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);

      run_vec("zero_minus_one", 16'h0000, 16'h0001, 16'hFFFF, 1, 0, 0);
      run_vec("equal",          16'h1234, 16'h1234, 16'h0000, 0, 0, 1);
      run_vec("min_minus_one",  16'h8000, 16'h0001, 16'h7FFF, 0, 1, 0);
      run_vec("max_minus_neg1", 16'h7FFF, 16'hFFFF, 16'h8000, 1, 1, 0);
      run_vec("ffff_minus_one", 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0, 0);
      run_vec("zero_minus_min", 16'h0000, 16'h8000, 16'h8000, 1, 1, 0);
      run_vec("abcd_1234",      16'hABCD, 16'h1234, 16'h9999, 0, 0, 0);
      run_vec("ripple_borrow",  16'h1000, 16'h0FFF, 16'h0001, 0, 0, 0);

      // start held high; operands disturbed mid-RUN and restored before each done cycle
      @(negedge clk);
      a = 16'h00F0; b = 16'h000F; start = 1'b1;
      @(posedge clk);
      ndone = 0;
      for (int n = 1; n <= 15; n++) begin
         @(negedge clk);
         if (n % 5 == 2) begin a = 16'hFFFF; b = 16'h1234; end
         if (n % 5 == 4) begin a = 16'h00F0; b = 16'h000F; end
         if (n % 5 == 0) begin
            check("b2b_done", done, 1);
            check("b2b_diff", diff, 16'h00E1);
            check("b2b_busy_at_done", busy, 0);
            if (done) ndone++;
         end else begin
            check("b2b_busy", busy, 1);
            check("b2b_no_done", done, 0);
         end
         if (n == 15) start = 1'b0;
      end
      check("b2b_done_count", ndone, 3);
      @(negedge clk);
      check("b2b_idle_busy", busy, 0);
      check("b2b_idle_done", done, 0);

      // reset asserted in the second RUN cycle aborts the operation
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("abort_running", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check_cleared("abort");
      rst_n = 1'b1;
      ndone = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      check("abort_no_done", ndone, 0);
      run_vec("after_abort", 16'h000A, 16'h0003, 16'h0007, 0, 0, 0);

      // random sweep against arithmetic reference
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rd = ra - rb;
         run_vec("sweep", ra, rb, rd, ra < rb,
                 (ra[15] != rb[15]) && (rd[15] != ra[15]), rd == 16'h0000);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
